// File: rtl/matmul_tile_scheduler_pkg.sv
// ============================================================================
//  Module   : mm_pkg
//  Brief    : Shared state encodings, counter widths and index-width helper
//             for the matmul tile scheduler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mm_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_NEXT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int WR_CNT_W  = 16;
    localparam int CYC_CNT_W = 32;

    // Never returns zero so a single-value index still gets a 1-bit port.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_tile_scheduler_if.sv
// ============================================================================
//  Module   : matmul_tile_scheduler_if
//  Brief    : Controller, engine and result-memory signals of the scheduler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface matmul_tile_scheduler_if #(
    parameter int M    = 4,
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    import mm_pkg::*;

    localparam int TR_W = idx_w(ROWS / M);
    localparam int TC_W = idx_w(COLS / M);
    localparam int L_W  = idx_w(M);
    localparam int AR_W = idx_w(ROWS);
    localparam int AC_W = idx_w(COLS);

    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic [TR_W-1:0]      tile_r;
    logic [TC_W-1:0]      tile_c;
    logic                 eng_rst;
    logic                 eng_start;
    logic                 eng_done;
    logic [L_W-1:0]       eng_a_i;
    logic [L_W-1:0]       eng_b_j;
    logic [L_W-1:0]       eng_z_i;
    logic [L_W-1:0]       eng_z_j;
    logic                 eng_z_stb;
    logic                 eng_z_ack;
    logic [AR_W-1:0]      a_row;
    logic [AC_W-1:0]      b_col;
    logic [AR_W-1:0]      z_row;
    logic [AC_W-1:0]      z_col;
    logic                 res_stb;
    logic                 res_ack;
    logic [WR_CNT_W-1:0]  wr_count;
    logic [CYC_CNT_W-1:0] cyc_count;

    modport master (
        input  start, abort, eng_done, eng_a_i, eng_b_j, eng_z_i, eng_z_j,
               eng_z_stb, res_ack,
        output busy, done, tile_r, tile_c, eng_rst, eng_start, eng_z_ack,
               a_row, b_col, z_row, z_col, res_stb, wr_count, cyc_count
    );

    modport slave (
        output start, abort, eng_done, eng_a_i, eng_b_j, eng_z_i, eng_z_j,
               eng_z_stb, res_ack,
        input  busy, done, tile_r, tile_c, eng_rst, eng_start, eng_z_ack,
               a_row, b_col, z_row, z_col, res_stb, wr_count, cyc_count
    );

endinterface

`default_nettype wire

// File: rtl/matmul_tile_scheduler_tile_counter.sv
// ============================================================================
//  Module   : tile_counter
//  Brief    : Row-major 2-D index counter with clear, increment and a flag
//             marking the final position; the row holds on the final step.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tile_counter #(
    parameter int ROWS_N = 2,
    parameter int COLS_N = 2,
    parameter int R_W    = 1,
    parameter int C_W    = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           clr,
    input  wire logic           inc,
    output logic [R_W-1:0]      row,
    output logic [C_W-1:0]      col,
    output logic                wrap
);

    logic [R_W-1:0] r_row;
    logic [C_W-1:0] r_col;
    logic           w_last_col;
    logic           w_last_row;

    assign w_last_col = (r_col == C_W'(COLS_N - 1));
    assign w_last_row = (r_row == R_W'(ROWS_N - 1));
    assign wrap       = w_last_col & w_last_row;
    assign row        = r_row;
    assign col        = r_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (inc) begin
            if (w_last_col) begin
                r_col <= '0;
                if (!w_last_row) begin
                    r_row <= r_row + R_W'(1);
                end
            end else begin
                r_col <= r_col + C_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/matmul_tile_scheduler.sv
// ============================================================================
//  Module   : matmul_tile_scheduler
//  Brief    : Walks MxM output tiles row-major over a ROWSxCOLS result,
//             arming one engine per tile and mapping its local indices.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module matmul_tile_scheduler
    import mm_pkg::*;
#(
    parameter int N    = 8,
    parameter int M    = 4,
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  wire logic                clk,
    input  wire logic                rst,
    matmul_tile_scheduler_if.master  bus
);

    localparam int c_TILES_R = ROWS / M;
    localparam int c_TILES_C = COLS / M;
    localparam int c_TR_W    = idx_w(c_TILES_R);
    localparam int c_TC_W    = idx_w(c_TILES_C);
    localparam int c_AR_W    = idx_w(ROWS);
    localparam int c_AC_W    = idx_w(COLS);

    if ((ROWS % M) != 0) begin : g_chk_rows
        $error("matmul_tile_scheduler: ROWS must be a multiple of M");
    end
    if ((COLS % M) != 0) begin : g_chk_cols
        $error("matmul_tile_scheduler: COLS must be a multiple of M");
    end
    if (N < 1) begin : g_chk_n
        $error("matmul_tile_scheduler: N must be at least 1");
    end

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic                 r_eng_rst;
    logic                 r_eng_start;
    logic                 r_done;
    logic [WR_CNT_W-1:0]  r_wr_count;
    logic [CYC_CNT_W-1:0] r_cyc_count;
    logic                 w_busy;
    logic                 w_clr;
    logic                 w_inc;
    logic                 w_wrap;
    logic                 w_wr_fire;
    logic [c_TR_W-1:0]    w_tile_r;
    logic [c_TC_W-1:0]    w_tile_c;

    tile_counter #(
        .ROWS_N (c_TILES_R),
        .COLS_N (c_TILES_C),
        .R_W    (c_TR_W),
        .C_W    (c_TC_W)
    ) u_tile_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .inc  (w_inc),
        .row  (w_tile_r),
        .col  (w_tile_c),
        .wrap (w_wrap)
    );

    assign w_busy    = (r_state != S_IDLE);
    assign w_wr_fire = bus.res_stb & bus.res_ack;

    // Abort overrides every transition, including eng_done and the tile step.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_ARM;
                    w_clr       = 1'b1;
                end
            end
            S_ARM:  w_state_nxt = S_RUN;
            S_RUN: begin
                if (bus.eng_done) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                w_inc       = 1'b1;
                w_state_nxt = w_wrap ? S_DONE : S_ARM;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.abort && w_busy) begin
            w_state_nxt = S_IDLE;
            w_inc       = 1'b0;
        end
    end

    // Engine controls are decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_eng_rst   <= 1'b1;
            r_eng_start <= 1'b0;
            r_done      <= 1'b0;
            r_wr_count  <= '0;
            r_cyc_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_eng_rst   <= (w_state_nxt != S_RUN);
            r_eng_start <= (w_state_nxt == S_RUN);
            r_done      <= (w_state_nxt == S_DONE);
            if (w_clr) begin
                r_wr_count  <= '0;
                r_cyc_count <= '0;
            end else begin
                if (w_wr_fire && (r_wr_count != '1)) begin
                    r_wr_count <= r_wr_count + WR_CNT_W'(1);
                end
                if (w_busy && (r_cyc_count != '1)) begin
                    r_cyc_count <= r_cyc_count + CYC_CNT_W'(1);
                end
            end
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.eng_rst   = r_eng_rst;
    assign bus.eng_start = r_eng_start;
    assign bus.tile_r    = w_tile_r;
    assign bus.tile_c    = w_tile_c;
    assign bus.wr_count  = r_wr_count;
    assign bus.cyc_count = r_cyc_count;
    assign bus.eng_z_ack = bus.res_ack;
    assign bus.res_stb   = (r_state == S_RUN) & bus.eng_z_stb;

    assign bus.a_row = c_AR_W'(int'(w_tile_r) * M + int'(bus.eng_a_i));
    assign bus.b_col = c_AC_W'(int'(w_tile_c) * M + int'(bus.eng_b_j));
    assign bus.z_row = c_AR_W'(int'(w_tile_r) * M + int'(bus.eng_z_i));
    assign bus.z_col = c_AC_W'(int'(w_tile_c) * M + int'(bus.eng_z_j));

endmodule

`default_nettype wire

// File: tb/tb_matmul_tile_scheduler.sv
// ============================================================================
//  Module   : tb_matmul_tile_scheduler
//  Brief    : Self-checking bench; an expected per-cycle timeline is built
//             from the tiling rules and drives a behavioural engine.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_matmul_tile_scheduler;

    localparam int c_M     = 4;
    localparam int c_ROWS  = 8;
    localparam int c_COLS  = 8;
    localparam int c_TR    = c_ROWS / c_M;
    localparam int c_TC    = c_COLS / c_M;
    localparam int c_TILES = c_TR * c_TC;
    localparam int P_ARM   = 1;
    localparam int P_RUN   = 2;
    localparam int P_NEXT  = 3;
    localparam int P_DONE  = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    matmul_tile_scheduler_if #(.M(c_M), .ROWS(c_ROWS), .COLS(c_COLS)) bus ();

    matmul_tile_scheduler #(.N(8), .M(c_M), .ROWS(c_ROWS), .COLS(c_COLS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_idle();
        bus.start = 0; bus.abort = 0; bus.eng_done = 0; bus.eng_z_stb = 0; bus.res_ack = 0;
        bus.eng_a_i = 0; bus.eng_b_j = 0; bus.eng_z_i = 0; bus.eng_z_j = 0;
    endtask

    // kill_mode: 0 none, 1 abort, 2 rst. Expected behaviour comes from a timeline of phases.
    task automatic run_job(input int kill_tile, input int kill_mode, input bit kill_on_done,
                           input bit poke, input bit directed);
        int  q_ph[$], q_tr[$], q_tc[$], q_k[$], q_rc[$];
        bit  q_last[$];
        int  exp_wr, exp_cyc, ai, bj, zi, zj, fin_tr, fin_tc;
        bit  stb, ack, is_run, kill;
        for (int k = 0; k < c_TILES; k++) begin
            int lat;
            int kc;
            lat = directed ? int'($urandom_range(5, 8)) : int'($urandom_range(1, 9));
            kc  = -1;
            if (kill_mode != 0 && k == kill_tile)
                kc = kill_on_done ? lat : int'($urandom_range(0, lat - 1));
            q_ph.push_back(P_ARM); q_tr.push_back(k / c_TC); q_tc.push_back(k % c_TC);
            q_k.push_back(k); q_rc.push_back(0); q_last.push_back(1'b0);
            for (int r = 0; r <= lat; r++) begin
                q_ph.push_back(P_RUN); q_tr.push_back(k / c_TC); q_tc.push_back(k % c_TC);
                q_k.push_back(k); q_rc.push_back(r); q_last.push_back(r == lat);
                if (r == kc) break;
            end
            if (kc >= 0) break;
            q_ph.push_back(P_NEXT); q_tr.push_back(k / c_TC); q_tc.push_back(k % c_TC);
            q_k.push_back(k); q_rc.push_back(0); q_last.push_back(1'b0);
        end
        if (kill_mode == 0) begin
            q_ph.push_back(P_DONE); q_tr.push_back(c_TR - 1); q_tc.push_back(0);
            q_k.push_back(c_TILES - 1); q_rc.push_back(0); q_last.push_back(1'b0);
        end
        fin_tr = q_tr[q_tr.size() - 1];
        fin_tc = q_tc[q_tc.size() - 1];

        @(negedge clk);
        drive_idle();
        bus.start = 1'b1;
        exp_wr  = 0;
        exp_cyc = 0;
        for (int c = 0; c < q_ph.size(); c++) begin
            @(negedge clk);
            is_run = (q_ph[c] == P_RUN);
            kill   = (kill_mode != 0) && (c == q_ph.size() - 1);
            bus.start    = poke && is_run && q_k[c] == 1 && ($urandom_range(0, 1) == 1);
            bus.eng_done = is_run ? q_last[c] : ($urandom_range(0, 3) == 0);
            bus.abort    = kill && kill_mode == 1;
            if (directed) begin
                stb = is_run && q_k[c] == 0 && q_rc[c] < 4;
                ack = is_run && q_k[c] == 0 && q_rc[c] == 3;
            end else begin
                stb = ($urandom_range(0, 1) == 1);
                ack = ($urandom_range(0, 1) == 1);
            end
            ai = $urandom_range(0, c_M - 1); bj = $urandom_range(0, c_M - 1);
            zi = $urandom_range(0, c_M - 1); zj = $urandom_range(0, c_M - 1);
            if (directed && is_run && q_k[c] == 3) begin ai = 1; bj = 0; zi = 3; zj = 2; end
            bus.eng_z_stb = stb; bus.res_ack = ack;
            bus.eng_a_i = 2'(ai); bus.eng_b_j = 2'(bj); bus.eng_z_i = 2'(zi); bus.eng_z_j = 2'(zj);
            #1;
            n_checks++; if (bus.busy !== 1'b1) $display("FAIL busy c=%0d got %b exp 1", c, bus.busy); else n_pass++;
            n_checks++; if (bus.done !== (q_ph[c] == P_DONE)) $display("FAIL done c=%0d got %b exp %b", c, bus.done, q_ph[c] == P_DONE); else n_pass++;
            n_checks++; if (bus.eng_start !== is_run) $display("FAIL eng_start c=%0d got %b exp %b", c, bus.eng_start, is_run); else n_pass++;
            n_checks++; if (bus.eng_rst !== !is_run) $display("FAIL eng_rst c=%0d got %b exp %b", c, bus.eng_rst, !is_run); else n_pass++;
            n_checks++; if (int'(bus.tile_r) !== q_tr[c]) $display("FAIL tile_r c=%0d got %0d exp %0d", c, bus.tile_r, q_tr[c]); else n_pass++;
            n_checks++; if (int'(bus.tile_c) !== q_tc[c]) $display("FAIL tile_c c=%0d got %0d exp %0d", c, bus.tile_c, q_tc[c]); else n_pass++;
            n_checks++; if (int'(bus.a_row) !== q_tr[c] * c_M + ai) $display("FAIL a_row c=%0d got %0d exp %0d", c, bus.a_row, q_tr[c] * c_M + ai); else n_pass++;
            n_checks++; if (int'(bus.b_col) !== q_tc[c] * c_M + bj) $display("FAIL b_col c=%0d got %0d exp %0d", c, bus.b_col, q_tc[c] * c_M + bj); else n_pass++;
            n_checks++; if (int'(bus.z_row) !== q_tr[c] * c_M + zi) $display("FAIL z_row c=%0d got %0d exp %0d", c, bus.z_row, q_tr[c] * c_M + zi); else n_pass++;
            n_checks++; if (int'(bus.z_col) !== q_tc[c] * c_M + zj) $display("FAIL z_col c=%0d got %0d exp %0d", c, bus.z_col, q_tc[c] * c_M + zj); else n_pass++;
            n_checks++; if (bus.res_stb !== (stb && is_run)) $display("FAIL res_stb c=%0d got %b exp %b", c, bus.res_stb, stb && is_run); else n_pass++;
            n_checks++; if (bus.eng_z_ack !== ack) $display("FAIL eng_z_ack c=%0d got %b exp %b", c, bus.eng_z_ack, ack); else n_pass++;
            n_checks++; if (int'(bus.wr_count) !== exp_wr) $display("FAIL wr_count c=%0d got %0d exp %0d", c, bus.wr_count, exp_wr); else n_pass++;
            n_checks++; if (int'(bus.cyc_count) !== exp_cyc) $display("FAIL cyc_count c=%0d got %0d exp %0d", c, bus.cyc_count, exp_cyc); else n_pass++;
            if (directed && is_run && q_k[c] == 3) begin
                n_checks++; if (bus.z_row !== 3'd7 || bus.z_col !== 3'd6) $display("FAIL z_addr11 got %0d,%0d exp 7,6", bus.z_row, bus.z_col); else n_pass++;
                n_checks++; if (bus.a_row !== 3'd5 || bus.b_col !== 3'd4) $display("FAIL ab_addr11 got %0d,%0d exp 5,4", bus.a_row, bus.b_col); else n_pass++;
            end
            if (kill && kill_mode == 2) begin
                rst = 1'b1;
                #1;
                n_checks++; if (bus.eng_rst !== 1'b1 || bus.eng_start !== 1'b0) $display("FAIL rst_eng got rst=%b start=%b exp 1,0", bus.eng_rst, bus.eng_start); else n_pass++;
                n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL rst_busy got busy=%b done=%b exp 0,0", bus.busy, bus.done); else n_pass++;
                n_checks++; if (bus.wr_count !== 16'd0 || bus.cyc_count !== 32'd0) $display("FAIL rst_counts got %0d,%0d exp 0,0", bus.wr_count, bus.cyc_count); else n_pass++;
                n_checks++; if (bus.tile_r !== 1'b0 || bus.tile_c !== 1'b0) $display("FAIL rst_tile got %0d,%0d exp 0,0", bus.tile_r, bus.tile_c); else n_pass++;
                @(posedge clk);
                @(negedge clk);
                drive_idle();
                rst = 1'b0;
                return;
            end
            if (stb && ack && is_run) exp_wr++;
            exp_cyc++;
        end
        // Idle afterwards: engine-side noise must have no effect.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_idle();
            bus.eng_done = 1'b1; bus.eng_z_stb = 1'b1; bus.res_ack = ($urandom_range(0, 1) == 1);
            #1;
            n_checks++; if (bus.busy !== 1'b0 || bus.done !== (i == 0 && kill_mode == 0 ? 1'b0 : 1'b0)) $display("FAIL idle_busy i=%0d got busy=%b done=%b exp 0,0", i, bus.busy, bus.done); else n_pass++;
            n_checks++; if (bus.eng_rst !== 1'b1 || bus.eng_start !== 1'b0) $display("FAIL idle_eng i=%0d got rst=%b start=%b exp 1,0", i, bus.eng_rst, bus.eng_start); else n_pass++;
            n_checks++; if (bus.res_stb !== 1'b0) $display("FAIL idle_res_stb i=%0d got %b exp 0", i, bus.res_stb); else n_pass++;
            n_checks++; if (int'(bus.wr_count) !== exp_wr || int'(bus.cyc_count) !== exp_cyc) $display("FAIL idle_counts got %0d,%0d exp %0d,%0d", bus.wr_count, bus.cyc_count, exp_wr, exp_cyc); else n_pass++;
            n_checks++; if (int'(bus.tile_r) !== fin_tr || int'(bus.tile_c) !== fin_tc) $display("FAIL idle_tile got %0d,%0d exp %0d,%0d", bus.tile_r, bus.tile_c, fin_tr, fin_tc); else n_pass++;
        end
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.eng_rst !== 1'b1 || bus.eng_start !== 1'b0) $display("FAIL reset_eng got rst=%b start=%b exp 1,0", bus.eng_rst, bus.eng_start); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_busy got busy=%b done=%b exp 0,0", bus.busy, bus.done); else n_pass++;
        n_checks++; if (bus.tile_r !== 1'b0 || bus.tile_c !== 1'b0) $display("FAIL reset_tile got %0d,%0d exp 0,0", bus.tile_r, bus.tile_c); else n_pass++;
        n_checks++; if (bus.wr_count !== 16'd0 || bus.cyc_count !== 32'd0) $display("FAIL reset_counts got %0d,%0d exp 0,0", bus.wr_count, bus.cyc_count); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_run();
        for (int i = 0; i < 3; i++) run_job(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_addr_and_ack();
        run_job(0, 0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.wr_count !== 16'd1) $display("FAIL ack_single_write got %0d exp 1", bus.wr_count); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        run_job(0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        run_job(2, 1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.tile_r !== 1'b1 || bus.tile_c !== 1'b0) $display("FAIL abort_tile got %0d,%0d exp 1,0", bus.tile_r, bus.tile_c); else n_pass++;
        run_job(1, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_rst_mid_run();
        run_job(1, 2, 1'b0, 1'b0, 1'b0);
        run_job(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_job(0, 0, 1'b0, 1'b1, 1'b0);
        run_job(3, 1, 1'b0, 1'b0, 1'b0);
        run_job(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_full_run();
        test_addr_and_ack();
        test_start_while_busy();
        test_abort();
        test_rst_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
